// File: rtl/int_scheduler_if.sv
// Interrupt scheduler bus interface.
// Bundles the IRQ inputs, register access port, IACK handshake and CPU-facing outputs.
//   master : drives IRQ sources, register writes/selects and IACK (bus decoder / testbench)
//   slave  : the scheduler itself
interface int_scheduler_if;
  logic [5:0]  irq_in;
  logic        reg_wr_in;
  logic [1:0]  reg_sel_in;
  logic [15:0] reg_wdata_in;
  logic [15:0] reg_rdata;
  logic        iack_in;
  logic [2:0]  iack_level_in;
  logic [2:0]  int_level;
  logic        iack_valid;
  logic        timer_tick;

  modport master (
    output irq_in, reg_wr_in, reg_sel_in, reg_wdata_in, iack_in, iack_level_in,
    input  reg_rdata, int_level, iack_valid, timer_tick
  );

  modport slave (
    input  irq_in, reg_wr_in, reg_sel_in, reg_wdata_in, iack_in, iack_level_in,
    output reg_rdata, int_level, iack_valid, timer_tick
  );
endinterface

// File: rtl/int_scheduler.sv
// 68000-style interrupt scheduler with an interval timer on level 1.
// Ports:
//   mclk_in  : clock, all state updates on its rising edge
//   reset_in : asynchronous reset, active-high
//   bus      : int_scheduler_if.slave
//              irq_in[5:0] -> levels 2..7, register port (MASK/RELOAD/CTRL/PENDING),
//              IACK strobe + level, registered int_level / iack_valid / timer_tick.
module int_scheduler #(
  parameter int unsigned TIMER_WIDTH = 16,
  parameter logic [5:0]  EDGE_MASK   = 6'b000011
) (
  input  logic           mclk_in,
  input  logic           reset_in,
  int_scheduler_if.slave bus
);

  // Level 1 (timer) always behaves as an edge/sticky source.
  localparam logic [7:1] EdgeLvl    = {EDGE_MASK, 1'b1};
  localparam logic [1:0] SelMask    = 2'd0;
  localparam logic [1:0] SelReload  = 2'd1;
  localparam logic [1:0] SelCtrl    = 2'd2;
  localparam logic [1:0] SelPending = 2'd3;

  logic [5:0]             irq_q, irq_prev_q;
  logic [7:1]             pending_q, pending_d, pend_set, pend_clr, level_src;
  logic [7:1]             mask_full, active;
  logic [6:1]             mask_q;
  logic [7:0]             pend_lvl, mask_lvl;
  logic [TIMER_WIDTH-1:0] reload_q, reload_d, count_q, count_d;
  logic                   en_q, en_d, expire, tick_q, grant, iack_valid_q;
  logic [2:0]             int_level_q, int_level_d;
  logic                   wr_mask, wr_reload, wr_ctrl, wr_pending;

  assign wr_mask    = bus.reg_wr_in && (bus.reg_sel_in == SelMask);
  assign wr_reload  = bus.reg_wr_in && (bus.reg_sel_in == SelReload);
  assign wr_ctrl    = bus.reg_wr_in && (bus.reg_sel_in == SelCtrl);
  assign wr_pending = bus.reg_wr_in && (bus.reg_sel_in == SelPending);

  // Level 7 is non-maskable.
  assign mask_full = {1'b1, mask_q};
  assign active    = pending_q & mask_full;

  // Slot 0 is hard-wired low so an IACK of level 0 can never grant.
  assign pend_lvl = {pending_q, 1'b0};
  assign mask_lvl = {mask_full, 1'b0};
  assign grant    = bus.iack_in && pend_lvl[bus.iack_level_in] && mask_lvl[bus.iack_level_in];

  // Interval timer. A RELOAD write or an enable rising edge (re)loads the counter and
  // takes priority over an expiry in the same cycle. RELOAD == 0 never expires.
  always_comb begin
    en_d     = wr_ctrl ? bus.reg_wdata_in[0] : en_q;
    reload_d = wr_reload ? TIMER_WIDTH'(bus.reg_wdata_in) : reload_q;
    expire   = 1'b0;
    count_d  = count_q;
    if (wr_reload || (en_d && !en_q)) begin
      count_d = reload_d;
    end else if (en_q) begin
      if (count_q != '0) begin
        count_d = count_q - TIMER_WIDTH'(1);
      end else if (reload_q != '0) begin
        expire  = 1'b1;
        count_d = reload_q;
      end
    end
  end

  // Pending: edge bits are sticky (set wins over clear), level bits follow the sample.
  always_comb begin
    pend_set  = {irq_q & ~irq_prev_q, expire};
    level_src = {irq_q, 1'b0};
    pend_clr  = '0;
    for (int i = 1; i <= 7; i++) begin
      pend_clr[i] = (wr_pending && bus.reg_wdata_in[i]) ||
                    (grant && (bus.iack_level_in == 3'(i)));
    end
    pending_d = (EdgeLvl & ((pending_q & ~pend_clr) | pend_set)) | (~EdgeLvl & level_src);
  end

  // Highest enabled pending level wins.
  always_comb begin
    int_level_d = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      if (active[i]) begin
        int_level_d = 3'(i);
      end
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_sel_in)
      SelMask:    bus.reg_rdata = {8'b0, mask_full, 1'b0};
      SelReload:  bus.reg_rdata = 16'(reload_q);
      SelCtrl:    bus.reg_rdata = {15'b0, en_q};
      default:    bus.reg_rdata = {8'b0, pending_q, 1'b0};
    endcase
  end

  always_ff @(posedge mclk_in or posedge reset_in) begin
    if (reset_in) begin
      irq_q        <= '0;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      reload_q     <= '0;
      en_q         <= 1'b0;
      count_q      <= '0;
      tick_q       <= 1'b0;
      int_level_q  <= 3'd0;
      iack_valid_q <= 1'b0;
    end else begin
      irq_q        <= bus.irq_in;
      irq_prev_q   <= irq_q;
      pending_q    <= pending_d;
      if (wr_mask) begin
        mask_q <= bus.reg_wdata_in[6:1];
      end
      reload_q     <= reload_d;
      en_q         <= en_d;
      count_q      <= count_d;
      tick_q       <= expire;
      int_level_q  <= int_level_d;
      iack_valid_q <= grant;
    end
  end

  assign bus.int_level  = int_level_q;
  assign bus.iack_valid = iack_valid_q;
  assign bus.timer_tick = tick_q;

endmodule

// File: doc/int_scheduler.md
INT_SCHEDULER -- requirements
Module: int_scheduler

Interface
REQ-001 Parameter TIMER_WIDTH, default 16, width of the interval timer counter and reload register.
REQ-002 Parameter EDGE_MASK, default 6'b000011, bit i=1 makes IRQ_IN[i] edge-triggered, 0 makes it level-triggered.
REQ-003 MCLK_IN  input  1  the single clock; all state is updated on its rising edge.
REQ-004 RESET_IN  input  1  asynchronous reset, active-high.
REQ-005 IRQ_IN  input  6  raw interrupt sources; bit i requests 68000 level i+2.
REQ-006 REG_WR_IN  input  1  one-cycle register write strobe.
REQ-007 REG_SEL_IN  input  2  register select: 0 MASK, 1 RELOAD, 2 CTRL, 3 PENDING.
REQ-008 REG_WDATA_IN  input  16  write data.
REQ-009 REG_RDATA  output  16  combinational read of the register selected by REG_SEL_IN.
REQ-010 IACK_IN  input  1  one-cycle interrupt-acknowledge strobe from the bus decoder.
REQ-011 IACK_LEVEL_IN  input  3  level being acknowledged (A3..A1).
REQ-012 INT_LEVEL  output  3  encoded request level to the CPU IPL pins (0 = none).
REQ-013 IACK_VALID  output  1  registered autovector grant, feeds AVEC.
REQ-014 TIMER_TICK  output  1  one-cycle pulse on each timer expiry.

Function
REQ-015 Level 1 is the internal interval timer; levels 2..7 map to IRQ_IN[0..5].
REQ-016 PENDING[7:1] is a register; PENDING[i] for an edge source sets on the cycle after a 0->1 transition of the registered IRQ sample.
REQ-017 A level source's PENDING bit equals its registered IRQ sample, one cycle of latency, and is not changed by IACK or PENDING writes.
REQ-018 Edge-source PENDING bits clear on a PENDING write with the corresponding REG_WDATA_IN bit set (write-1-clear), or on a granted IACK of that level.
REQ-019 A set and a clear of the same PENDING bit in one cycle leaves the bit set.
REQ-020 MASK[7:1]: bit=1 enables the level; MASK[7] reads 1 and ignores writes (level 7 is non-maskable).
REQ-021 INT_LEVEL is registered: the highest i with PENDING[i] & MASK[i], updated one cycle after PENDING/MASK change; 0 if none.
REQ-022 On IACK_IN, IACK_VALID asserts the next cycle for exactly one cycle if PENDING[IACK_LEVEL_IN] & MASK[IACK_LEVEL_IN]; otherwise it stays 0 (bus decoder issues BERR).
REQ-023 IACK_IN with level 0 never grants.
REQ-024 CTRL bit0 = timer enable; CTRL bits 15:1 read 0.
REQ-025 Timer: counter loads RELOAD when enable goes 0->1 or RELOAD is written; while enabled it decrements by 1 per cycle.
REQ-026 Counter at 0 while enabled: TIMER_TICK pulses, PENDING[1] sets, counter reloads from RELOAD; the period is RELOAD+1 cycles.
REQ-027 RELOAD = 0 disables expiry: no ticks and the counter holds 0.
REQ-028 Disabling the timer freezes the counter and clears no pending state.
REQ-029 REG_RDATA for PENDING returns {8'b0, PENDING[7:1], 1'b0}; for MASK returns {8'b0, MASK[7:1], 1'b0}; for RELOAD returns RELOAD zero-extended.

Reset
REQ-030 While RESET_IN=1: PENDING=0, MASK[6:1]=0, RELOAD=0, CTRL=0, counter=0, IRQ samples=0, INT_LEVEL=0, IACK_VALID=0, TIMER_TICK=0.
REQ-031 An IRQ_IN held high through reset release is seen as a 0->1 edge on the first sampled cycle.
REQ-032 Reset asserted mid-count or mid-IACK aborts immediately; no tick or grant is emitted.

Verification
REQ-033 MASK=0x00FE, pulse IRQ_IN[0] for 1 cycle -> INT_LEVEL=2 two cycles later; IACK level 2 -> IACK_VALID one cycle, PENDING[2]=0, INT_LEVEL=0.
REQ-034 Edge IRQ_IN[0] and level IRQ_IN[3] both high, MASK all -> INT_LEVEL=5; IACK 5 -> grant, PENDING[5] stays 1, INT_LEVEL stays 5.
REQ-035 RELOAD=3, CTRL=1 -> TIMER_TICK every 4 cycles, PENDING[1]=1; write RELOAD=0 -> no further ticks.
REQ-036 MASK=0, IRQ_IN[5] rising -> INT_LEVEL=7; IACK 3 with nothing pending -> IACK_VALID stays 0.
REQ-037 PENDING W1C of bit 2 in the same cycle as a new IRQ_IN[0] edge -> PENDING[2] remains 1.
REQ-038 Timer running at count 1, RESET_IN pulsed -> no TIMER_TICK, all registers return to their reset values.
